// File: rtl/wrreg_stm.sv
// HyperRAM register-write engine: CS# setup, three CA words, one data word,
// CS# hold and recovery, then a level stm_end handshake with the selector.
module wrreg_stm #(
   parameter int CS_SETUP_CYC  = 2,
   parameter int CS_HOLD_CYC   = 2,
   parameter int RECOVERY_CYC  = 2,
   parameter bit FORCE_CA_BITS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stm_start,
   output logic        stm_end,
   output logic        oe,
   output logic        oe_clk,
   output logic        csn,
   output logic [15:0] datain,
   input  logic        rwds_in,
   input  logic [47:0] casig,
   input  logic [15:0] reg_wdata
);

   localparam int MAX_A = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
   localparam int MAX_P = (MAX_A > RECOVERY_CYC) ? MAX_A : RECOVERY_CYC;
   localparam int CNT_W = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'((RECOVERY_CYC > 0) ? RECOVERY_CYC - 1 : 0);

   if (CS_SETUP_CYC < 1) begin : g_bad_setup
      $error("wrreg_stm: CS_SETUP_CYC must be >= 1");
   end
   if (CS_HOLD_CYC < 1) begin : g_bad_hold
      $error("wrreg_stm: CS_HOLD_CYC must be >= 1");
   end
   if (RECOVERY_CYC < 0) begin : g_bad_recov
      $error("wrreg_stm: RECOVERY_CYC must be >= 0");
   end

   typedef enum logic [3:0] {
      IDLE, SETUP, CA0, CA1, CA2, DATA, HOLD, RECOV, DONE
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [47:0]       ca_q;
   logic [15:0]       wd_q;
   logic              csn_nx, oe_nx, oe_clk_nx, stm_end_nx;
   logic [15:0]       datain_nx;

   // Register writes have zero latency, so RWDS carries no information here.
   logic rwds_unused;
   assign rwds_unused = rwds_in;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE:  if (stm_start) begin
                   state_nx = SETUP;
                   cnt_nx   = SETUP_LD;
                end
         SETUP: if (cnt == '0) state_nx = CA0;
                else           cnt_nx   = cnt - 1'b1;
         CA0:   state_nx = CA1;
         CA1:   state_nx = CA2;
         CA2:   state_nx = DATA;
         DATA:  begin
                   state_nx = HOLD;
                   cnt_nx   = HOLD_LD;
                end
         HOLD:  if (cnt != '0)          cnt_nx   = cnt - 1'b1;
                else if (RECOVERY_CYC == 0) state_nx = DONE;
                else begin
                   state_nx = RECOV;
                   cnt_nx   = RECOV_LD;
                end
         RECOV: if (cnt == '0) state_nx = DONE;
                else           cnt_nx   = cnt - 1'b1;
         DONE:  if (!stm_start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the pads change on the same edge as the state.
   always_comb begin
      csn_nx     = 1'b1;
      oe_nx      = 1'b0;
      oe_clk_nx  = 1'b0;
      stm_end_nx = 1'b0;
      datain_nx  = 16'h0;
      unique case (state_nx)
         SETUP, HOLD: csn_nx = 1'b0;
         CA0, CA1, CA2, DATA: begin
            csn_nx    = 1'b0;
            oe_nx     = 1'b1;
            oe_clk_nx = 1'b1;
            case (state_nx)
               CA0:     datain_nx = ca_q[47:32];
               CA1:     datain_nx = ca_q[31:16];
               CA2:     datain_nx = ca_q[15:0];
               default: datain_nx = wd_q;
            endcase
         end
         DONE:    stm_end_nx = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ca_q    <= '0;
         wd_q    <= '0;
         csn     <= 1'b1;
         oe      <= 1'b0;
         oe_clk  <= 1'b0;
         stm_end <= 1'b0;
         datain  <= 16'h0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         csn     <= csn_nx;
         oe      <= oe_nx;
         oe_clk  <= oe_clk_nx;
         stm_end <= stm_end_nx;
         datain  <= datain_nx;
         if (state == IDLE && stm_start) begin
            ca_q <= FORCE_CA_BITS ? {2'b01, casig[45:0]} : casig;
            wd_q <= reg_wdata;
         end
      end
   end

endmodule
